// File: rtl/bsg_blackparrot_dram_interleaver.sv
// bsg_blackparrot_dram_interleaver: steers core mem commands to two DRAM links by a paddr bit
// and returns responses in issue order. Optional counters: BSG_DRAM_INTERLEAVE_PERF_EN.
module bsg_blackparrot_dram_interleaver #(
    parameter int msg_width_p       = 64,
    parameter int addr_lsb_p        = 0,
    parameter int sel_bit_p         = 6,
    parameter int max_outstanding_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [msg_width_p-1:0]      cmd_i,
    input  logic                        cmd_v_i,
    output logic                        cmd_ready_o,
    output logic [msg_width_p-1:0]      resp_o,
    output logic                        resp_v_o,
    input  logic                        resp_yumi_i,
    output logic [1:0][msg_width_p-1:0] link_cmd_o,
    output logic [1:0]                  link_cmd_v_o,
    input  logic [1:0]                  link_cmd_ready_i,
    input  logic [1:0][msg_width_p-1:0] link_resp_i,
    input  logic [1:0]                  link_resp_v_i,
    output logic [1:0]                  link_resp_yumi_o
`ifdef BSG_DRAM_INTERLEAVE_PERF_EN
    ,
    output logic [1:0][31:0]            issue_cnt_o,
    output logic [31:0]                 full_stall_cnt_o,
    output logic [31:0]                 hol_stall_cnt_o
`endif
);
    localparam int ptr_w_lp = $clog2(max_outstanding_p);
    localparam int sel_idx_lp = addr_lsb_p + sel_bit_p;
    localparam logic [ptr_w_lp:0] depth_lp = (ptr_w_lp + 1)'(max_outstanding_p);

    logic [max_outstanding_p-1:0] order_r;
    logic [ptr_w_lp-1:0]          rd_ptr_r;
    logic [ptr_w_lp-1:0]          wr_ptr_r;
    logic [ptr_w_lp:0]            count_r;

    logic sel;
    logic head;
    logic busy;
    logic full;
    logic cmd_fire;
    logic resp_deq;

    assign sel  = cmd_i[sel_idx_lp];
    assign head = order_r[rd_ptr_r];
    assign busy = count_r != '0;
    assign full = count_r == depth_lp;

    assign link_cmd_o      = {cmd_i, cmd_i};
    assign link_cmd_v_o[0] = reset_n_i & cmd_v_i & ~full & ~sel;
    assign link_cmd_v_o[1] = reset_n_i & cmd_v_i & ~full & sel;
    assign cmd_ready_o     = reset_n_i & ~full & link_cmd_ready_i[sel];
    assign cmd_fire        = cmd_v_i & cmd_ready_o;

    // Only the oldest outstanding link may answer; the other link holds its message.
    assign resp_v_o            = busy & link_resp_v_i[head];
    assign resp_o              = link_resp_i[head];
    assign resp_deq            = resp_yumi_i & resp_v_o;
    assign link_resp_yumi_o[0] = resp_deq & ~head;
    assign link_resp_yumi_o[1] = resp_deq & head;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            order_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (cmd_fire) begin
                order_r[wr_ptr_r] <= sel;
                wr_ptr_r          <= wr_ptr_r + 1'b1;
            end
            if (resp_deq) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            unique case ({cmd_fire, resp_deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef BSG_DRAM_INTERLEAVE_PERF_EN
    logic hol_stall;
    assign hol_stall = busy & link_resp_v_i[~head] & ~link_resp_v_i[head];

    for (genvar k = 0; k < 2; k++) begin : g_issue
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                issue_cnt_o[k] <= '0;
            end else if (cmd_fire && (sel == 1'(k)) && !(&issue_cnt_o[k])) begin
                issue_cnt_o[k] <= issue_cnt_o[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_stall_cnt_o <= '0;
            hol_stall_cnt_o  <= '0;
        end else begin
            if (cmd_v_i && full && !(&full_stall_cnt_o)) begin
                full_stall_cnt_o <= full_stall_cnt_o + 1'b1;
            end
            if (hol_stall && !(&hol_stall_cnt_o)) begin
                hol_stall_cnt_o <= hol_stall_cnt_o + 1'b1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_resp_when_empty: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (link_resp_v_i != 2'b00) |-> busy
    ) else $error("link response valid with no command outstanding");

    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        resp_yumi_i |-> resp_v_o
    ) else $error("resp_yumi_i asserted without resp_v_o");
`endif
endmodule

// File: tb/tb_bsg_blackparrot_dram_interleaver.sv
// tb_bsg_blackparrot_dram_interleaver: table vectors, directed corner sequences and
// random traffic checked against an in-order queue model of the interleaver.
module tb_bsg_blackparrot_dram_interleaver;
    localparam int MW    = 64;
    localparam int DEPTH = 8;

    logic                clk;
    logic                reset_n;
    logic [MW-1:0]       cmd;
    logic                cmd_v;
    logic                cmd_ready;
    logic [MW-1:0]       resp;
    logic                resp_v;
    logic                resp_yumi;
    logic [1:0][MW-1:0]  link_cmd;
    logic [1:0]          link_cmd_v;
    logic [1:0]          link_cmd_ready;
    logic [1:0][MW-1:0]  link_resp;
    logic [1:0]          link_resp_v;
    logic [1:0]          link_resp_yumi;
`ifdef BSG_DRAM_INTERLEAVE_PERF_EN
    logic [1:0][31:0]    issue_cnt;
    logic [31:0]         full_stall_cnt;
    logic [31:0]         hol_stall_cnt;
`endif

    bsg_blackparrot_dram_interleaver #(
        .msg_width_p      (MW),
        .addr_lsb_p       (0),
        .sel_bit_p        (6),
        .max_outstanding_p(DEPTH)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .cmd_i           (cmd),
        .cmd_v_i         (cmd_v),
        .cmd_ready_o     (cmd_ready),
        .resp_o          (resp),
        .resp_v_o        (resp_v),
        .resp_yumi_i     (resp_yumi),
        .link_cmd_o      (link_cmd),
        .link_cmd_v_o    (link_cmd_v),
        .link_cmd_ready_i(link_cmd_ready),
        .link_resp_i     (link_resp),
        .link_resp_v_i   (link_resp_v),
        .link_resp_yumi_o(link_resp_yumi)
`ifdef BSG_DRAM_INTERLEAVE_PERF_EN
        ,
        .issue_cnt_o     (issue_cnt),
        .full_stall_cnt_o(full_stall_cnt),
        .hol_stall_cnt_o (hol_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;
    int n_iss [2];

    // Model: commands in issue order; a link answers with ~cmd for its oldest pending command.
    logic [MW-1:0] exp_q [$];
    logic [1:0]    pres;

    typedef struct {
        logic [MW-1:0] paddr;
        logic [1:0]    rdy;
        logic [1:0]    ev;
        logic          er;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input logic s);
        logic [MW-1:0] c;
        c = {$urandom, $urandom};
        c[6] = s;
        return c;
    endfunction

    task automatic step(input string tag, input logic cv, input logic [MW-1:0] c,
                        input logic [1:0] rdy, input logic [1:0] ren, input logic yen);
        logic [MW-1:0] pend [2];
        logic          has  [2];
        logic          s, full, e_rdy, e_rv, hd, y;
        logic [1:0]    e_cv, e_y;
        for (int k = 0; k < 2; k++) begin
            has[k]  = 1'b0;
            pend[k] = '0;
            foreach (exp_q[i]) begin
                if (!has[k] && exp_q[i][6] == k[0]) begin
                    has[k]  = 1'b1;
                    pend[k] = exp_q[i];
                end
            end
            pres[k]        = has[k] && (pres[k] || ren[k]);
            link_resp_v[k] = pres[k];
            link_resp[k]   = pres[k] ? ~pend[k] : '0;
        end
        s     = c[6];
        full  = exp_q.size() == DEPTH;
        e_rdy = !full && rdy[s];
        e_cv  = (cv && !full) ? (s ? 2'b10 : 2'b01) : 2'b00;
        hd    = exp_q.size() > 0 ? exp_q[0][6] : 1'b0;
        e_rv  = exp_q.size() > 0 && pres[hd];
        y     = yen && e_rv;
        e_y   = y ? (hd ? 2'b10 : 2'b01) : 2'b00;
        cmd            = c;
        cmd_v          = cv;
        link_cmd_ready = rdy;
        resp_yumi      = y;
        #1;
        chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'(cv ? e_rdy : cmd_ready & e_rdy));
        chk({tag, " link_cmd_v"}, 64'(link_cmd_v), 64'(e_cv));
        chk({tag, " resp_v"}, 64'(resp_v), 64'(e_rv));
        chk({tag, " link_resp_yumi"}, 64'(link_resp_yumi), 64'(e_y));
        if (e_rv) chk({tag, " resp_data"}, resp, ~exp_q[0]);
        if (cv) begin
            chk({tag, " link_cmd0"}, link_cmd[0], c);
            chk({tag, " link_cmd1"}, link_cmd[1], c);
        end
        if (cv && e_rdy) begin
            exp_q.push_back(c);
            n_iss[s]++;
        end
        if (y) begin
            void'(exp_q.pop_front());
            pres[hd] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            step(tag, 1'b0, '0, 2'b11, 2'($urandom), 1'($urandom_range(0, 3) != 0));
            n++;
        end
        if (exp_q.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL %s drain timeout: %0d left want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    int issued;
    int cyc;
    int base;

    initial begin
        n_run = 0;
        n_fail = 0;
        n_iss[0] = 0;
        n_iss[1] = 0;
        pres = 2'b00;
        tbl[0] = '{64'h40, 2'b11, 2'b10, 1'b1};
        tbl[1] = '{64'h80, 2'b11, 2'b01, 1'b1};
        tbl[2] = '{64'h40, 2'b01, 2'b10, 1'b0};
        tbl[3] = '{64'h00, 2'b10, 2'b01, 1'b0};
        tbl[4] = '{64'hC0, 2'b10, 2'b10, 1'b1};
        tbl[5] = '{64'h3F, 2'b01, 2'b01, 1'b1};

        reset_n = 1'b0;
        cmd = '0;
        cmd_v = 1'b0;
        resp_yumi = 1'b0;
        link_cmd_ready = 2'b00;
        link_resp = '0;
        link_resp_v = 2'b00;
        @(posedge clk);
        #1;
        cmd = 64'h40;
        cmd_v = 1'b1;
        link_cmd_ready = 2'b11;
        #1;
        chk("reset cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset link_cmd_v", 64'(link_cmd_v), 64'd0);
        chk("reset resp_v", 64'(resp_v), 64'd0);
        chk("reset link_resp_yumi", 64'(link_resp_yumi), 64'd0);
        cmd_v = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            cmd = tbl[i].paddr;
            cmd_v = 1'b1;
            link_cmd_ready = tbl[i].rdy;
            #1;
            chk("tbl link_cmd_v", 64'(link_cmd_v), 64'(tbl[i].ev));
            chk("tbl cmd_ready", 64'(cmd_ready), 64'(tbl[i].er));
            step("tbl", 1'b1, tbl[i].paddr, tbl[i].rdy, 2'b00, 1'b0);
        end
        drain("tbl");

        step("ro_a", 1'b1, mk(1'b0), 2'b11, 2'b00, 1'b0);
        step("ro_b", 1'b1, mk(1'b1), 2'b11, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) step("ro_hold", 1'b0, '0, 2'b11, 2'b10, 1'b1);
        step("ro_a_out", 1'b0, '0, 2'b11, 2'b11, 1'b1);
        step("ro_b_out", 1'b0, '0, 2'b11, 2'b11, 1'b1);
        drain("ro");

        base = n_iss[0] + n_iss[1];
        issued = 0;
        cyc = 0;
        while ((issued < 20 || exp_q.size() > 0) && cyc < 2000) begin
            step("wrap", 1'(issued < 20 && $urandom_range(0, 2) != 0), mk(1'(issued % 2)),
                 2'($urandom), 2'($urandom), 1'($urandom_range(0, 2) != 0));
            issued = n_iss[0] + n_iss[1] - base;
            cyc++;
        end
        if (cyc >= 2000) begin
            n_run++;
            n_fail++;
            $display("FAIL wrap timeout: issued %0d left %0d want 20/0", issued, exp_q.size());
            exp_q.delete();
        end

        for (int i = 0; i < DEPTH; i++) step("full_fill", 1'b1, mk(1'(i % 2)), 2'b11, 2'b00, 1'b0);
        step("full_9th", 1'b1, mk(1'b0), 2'b11, 2'b00, 1'b0);
        step("full_deq", 1'b1, mk(1'b1), 2'b11, 2'b11, 1'b1);
        step("full_after", 1'b1, mk(1'b1), 2'b11, 2'b00, 1'b0);
        drain("full");

        for (int i = 0; i < 3; i++) step("sim_fill", 1'b1, mk(1'(i % 2)), 2'b11, 2'b00, 1'b0);
        step("sim_both", 1'b1, mk(1'b1), 2'b11, 2'b11, 1'b1);
        for (int i = 0; i < DEPTH - 3; i++) step("sim_top", 1'b1, mk(1'(i % 2)), 2'b11, 2'b00, 1'b0);
        step("sim_full", 1'b1, mk(1'b0), 2'b11, 2'b00, 1'b0);
        drain("sim");

        for (int i = 0; i < 5; i++) step("rst_fill", 1'b1, mk(1'(i % 2)), 2'b11, 2'b00, 1'b0);
        cmd = mk(1'b0);
        cmd_v = 1'b1;
        link_cmd_ready = 2'b11;
        link_resp_v = 2'b01;
        link_resp[0] = ~exp_q[0];
        #1;
        chk("rst_pre resp_v", 64'(resp_v), 64'd1);
        chk("rst_pre cmd_ready", 64'(cmd_ready), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid resp_v", 64'(resp_v), 64'd0);
        chk("rst_mid link_cmd_v", 64'(link_cmd_v), 64'd0);
        chk("rst_mid cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_mid link_resp_yumi", 64'(link_resp_yumi), 64'd0);
        cmd_v = 1'b0;
        link_resp_v = 2'b00;
        exp_q.delete();
        pres = 2'b00;
        n_iss[0] = 0;
        n_iss[1] = 0;
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", 1'b1, mk(1'b1), 2'b11, 2'b00, 1'b0);
        step("post_rst2", 1'b1, mk(1'b0), 2'b11, 2'b00, 1'b0);
        drain("post_rst");

`ifdef BSG_DRAM_INTERLEAVE_PERF_EN
        chk("issue_cnt0", 64'(issue_cnt[0]), 64'(n_iss[0]));
        chk("issue_cnt1", 64'(issue_cnt[1]), 64'(n_iss[1]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
